// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the LSU and data memory: handshake structs, widths,
// controller state and error encodings.
package lsu_mem_ctrl_pkg;

    localparam int data_width_lp = 32;

    typedef struct packed {
        logic                     valid;
        logic                     yumi;
        logic                     wen;
        logic                     byte_not_word;
        logic [data_width_lp-1:0] write_data;
    } mem_in_s;

    typedef struct packed {
        logic                     valid;
        logic                     yumi;
        logic [data_width_lp-1:0] read_data;
    } mem_out_s;

    localparam int mem_in_width_lp  = $bits(mem_in_s);
    localparam int mem_out_width_lp = $bits(mem_out_s);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        MISALIGN = 2'b01,
        TIMEOUT  = 2'b10
    } lsu_err_e;

endpackage

// File: rtl/lsu_mem_ctrl_load_extend.sv
// Formats raw memory read data into the 32-bit load result: word pass-through,
// or byte [7:0] zero- or sign-extended.
module load_extend
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [data_width_lp-1:0] read_data,
    input  logic                     byte_access,
    input  logic                     is_signed,
    output logic [data_width_lp-1:0] result
);

    logic fill;

    assign fill   = is_signed & read_data[7];
    assign result = byte_access ? {{(data_width_lp-8){fill}}, read_data[7:0]} : read_data;

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller between execute and the data memory,
// with misalignment rejection and a bounded wait for the memory response.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 12,
    parameter int timeout_p    = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_v_i,
    input  logic                        req_wen_i,
    input  logic                        req_byte_i,
    input  logic                        req_signed_i,
    input  logic [addr_width_p-1:0]     req_addr_i,
    input  logic [31:0]                 req_wdata_i,
    output logic                        ready_o,
    output logic                        resp_v_o,
    output logic [31:0]                 resp_data_o,
    output logic [1:0]                  resp_err_o,
    output logic [mem_in_width_lp-1:0]  mem_port_o,
    output logic [addr_width_p-1:0]     mem_addr_o,
    input  logic [mem_out_width_lp-1:0] mem_port_i
);

    localparam int cnt_width_lp = $clog2(timeout_p);

    lsu_state_e              state_reg, state_next;
    lsu_err_e                resp_err_reg, resp_err_next;
    logic [31:0]             resp_data_reg, resp_data_next;
    logic [cnt_width_lp-1:0] count_reg, count_next;
    logic                    wen_reg, byte_reg, signed_reg;
    logic [addr_width_p-1:0] addr_reg;
    logic [31:0]             wdata_reg;
    logic [31:0]             load_result;
    mem_in_s                 mem_in;
    mem_out_s                mem_out;

    assign mem_out     = mem_port_i;
    assign mem_port_o  = mem_in;
    assign mem_addr_o  = addr_reg;
    assign ready_o     = (state_reg == IDLE);
    assign resp_v_o    = (state_reg == DONE);
    assign resp_data_o = resp_data_reg;
    assign resp_err_o  = resp_err_reg;

    load_extend u_load_extend (
        .read_data   (mem_out.read_data),
        .byte_access (byte_reg),
        .is_signed   (signed_reg),
        .result      (load_result)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            resp_err_reg  <= OK;
            resp_data_reg <= '0;
            count_reg     <= '0;
            wen_reg       <= 1'b0;
            byte_reg      <= 1'b0;
            signed_reg    <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            resp_err_reg  <= resp_err_next;
            resp_data_reg <= resp_data_next;
            count_reg     <= count_next;
            if (state_reg == IDLE && req_v_i) begin
                wen_reg    <= req_wen_i;
                byte_reg   <= req_byte_i;
                signed_reg <= req_signed_i;
                addr_reg   <= req_addr_i;
                wdata_reg  <= req_wdata_i;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        resp_err_next  = resp_err_reg;
        resp_data_next = resp_data_reg;
        count_next     = count_reg;
        mem_in         = '0;
        case (state_reg)
            IDLE: begin
                if (req_v_i) begin
                    // Misaligned words complete without touching memory
                    if (!req_byte_i && (req_addr_i[1:0] != 2'b00)) begin
                        state_next     = DONE;
                        resp_err_next  = MISALIGN;
                        resp_data_next = '0;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                mem_in.valid         = 1'b1;
                mem_in.wen           = wen_reg;
                mem_in.byte_not_word = byte_reg;
                mem_in.write_data    = wdata_reg;
                if (mem_out.yumi) begin
                    state_next = WAIT;
                    count_next = '0;
                end
            end
            WAIT: begin
                mem_in.yumi = mem_out.valid;
                if (mem_out.valid) begin
                    state_next     = DONE;
                    resp_err_next  = OK;
                    resp_data_next = wen_reg ? 32'h0 : load_result;
                end else if (count_reg == cnt_width_lp'(timeout_p - 1)) begin
                    state_next     = DONE;
                    resp_err_next  = TIMEOUT;
                    resp_data_next = '0;
                end else begin
                    count_next = count_reg + cnt_width_lp'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a small byte-array memory model
// that can stall its acceptance or withhold its response.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_v, req_wen, req_byte, req_signed;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        ready_o, resp_v_o;
    logic [31:0] resp_data_o;
    logic [1:0]  resp_err_o;
    logic [mem_in_width_lp-1:0]  mem_port_o;
    logic [11:0]                 mem_addr_o;
    logic [mem_out_width_lp-1:0] mem_port_i;

    mem_in_s  mem_in;
    mem_out_s mem_out;
    assign mem_in     = mem_port_o;
    assign mem_port_i = mem_out;

    int n_checks = 0;
    int n_fails  = 0;
    int yumi_cnt = 0;
    int yumi_bad = 0;

    lsu_mem_ctrl #(.addr_width_p(12), .timeout_p(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_v_i      (req_v),
        .req_wen_i    (req_wen),
        .req_byte_i   (req_byte),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .ready_o      (ready_o),
        .resp_v_o     (resp_v_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .mem_port_o   (mem_port_o),
        .mem_addr_o   (mem_addr_o),
        .mem_port_i   (mem_port_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: accepts when not busy, answers one cycle later unless stalled
    logic [7:0]  mem_bytes [0:4095];
    logic        mem_pend, mem_stall, mem_refuse;
    logic [31:0] mem_rdata;
    int          a;

    assign mem_out.yumi      = mem_in.valid && !mem_pend && !mem_refuse;
    assign mem_out.valid     = mem_pend && !mem_stall;
    assign mem_out.read_data = mem_rdata;

    always @(posedge clk) begin
        if (!reset) begin
            mem_pend  <= 1'b0;
            mem_rdata <= 32'h0;
        end else if (mem_in.valid && mem_out.yumi) begin
            a = int'(mem_addr_o);
            mem_pend <= !mem_stall;
            if (mem_in.wen) begin
                mem_rdata <= 32'h12345678;
                mem_bytes[a] <= mem_in.write_data[7:0];
                if (!mem_in.byte_not_word) begin
                    mem_bytes[a+1] <= mem_in.write_data[15:8];
                    mem_bytes[a+2] <= mem_in.write_data[23:16];
                    mem_bytes[a+3] <= mem_in.write_data[31:24];
                end
            end else if (mem_in.byte_not_word) begin
                mem_rdata <= {24'hA5A5A5, mem_bytes[a]};
            end else begin
                mem_rdata <= {mem_bytes[a+3], mem_bytes[a+2], mem_bytes[a+1], mem_bytes[a]};
            end
        end else if (mem_in.yumi && mem_out.valid) begin
            mem_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mem_in.yumi) yumi_cnt++;
        if (mem_in.yumi && !mem_out.valid) yumi_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic wen, input logic bw, input logic sg,
                           input logic [11:0] addr, input logic [31:0] wd, input int hold,
                           output logic [31:0] data, output logic [1:0] err,
                           output int lat, output logic touched);
        int guard;
        touched = 1'b0;
        guard   = 0;
        while (!ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_v = 1'b1; req_wen = wen; req_byte = bw; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_v = 1'b0;
        lat   = 1;
        if (hold > 0) begin
            mem_refuse = 1'b1;
            for (int i = 0; i < hold; i++) begin
                check("req_hold_valid", 32'(mem_in.valid), 32'd1);
                check("req_hold_addr", 32'(mem_addr_o), 32'(addr));
                @(negedge clk);
                lat++;
            end
            mem_refuse = 1'b0;
        end
        while (!resp_v_o && lat < 100) begin
            if (mem_in.valid) touched = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("resp_within_bound", 32'(resp_v_o), 32'd1);
        data = resp_data_o;
        err  = resp_err_o;
        $display("txn wen=%0b byte=%0b signed=%0b addr=%h wdata=%h -> data=%h err=%0d lat=%0d",
                 wen, bw, sg, addr, wd, data, err, lat);
    endtask

    logic [31:0] d;
    logic [1:0]  e;
    int          lat;
    logic        touched;
    int          y0, nresp, acc;

    initial begin
        reset = 1'b0; req_v = 1'b0; req_wen = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; mem_stall = 1'b0; mem_refuse = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_resp_v", 32'(resp_v_o), 32'd0);
        check("rst_resp_data", resp_data_o, 32'h0);
        check("rst_resp_err", 32'(resp_err_o), 32'd0);
        check("rst_mem_port", 32'(mem_port_o != '0), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Nominal path: accept cycle, REQ, WAIT, then DONE on the third edge
        run_req(1'b1, 1'b0, 1'b0, 12'h010, 32'hDEADBEEF, 0, d, e, lat, touched);
        check("sw_err", 32'(e), 32'd0);
        check("sw_data", d, 32'h0);
        check("sw_lat", 32'(lat), 32'd3);
        run_req(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, d, e, lat, touched);
        check("lw_data", d, 32'hDEADBEEF);
        check("lw_err", 32'(e), 32'd0);
        check("lw_lat", 32'(lat), 32'd3);

        run_req(1'b1, 1'b1, 1'b0, 12'h021, 32'hAAAAAA80, 0, d, e, lat, touched);
        check("sb_err", 32'(e), 32'd0);
        check("sb_data", d, 32'h0);
        run_req(1'b0, 1'b1, 1'b1, 12'h021, 32'h0, 0, d, e, lat, touched);
        check("lb_signed", d, 32'hFFFFFF80);
        run_req(1'b0, 1'b1, 1'b0, 12'h021, 32'h0, 2, d, e, lat, touched);
        check("lbu", d, 32'h00000080);
        check("lbu_lat_held", 32'(lat), 32'd5);
        run_req(1'b0, 1'b1, 1'b0, 12'h013, 32'h0, 0, d, e, lat, touched);
        check("lbu_top_byte", d, 32'h000000DE);
        run_req(1'b0, 1'b1, 1'b1, 12'h012, 32'h0, 0, d, e, lat, touched);
        check("lb_neg_byte", d, 32'hFFFFFFAD);
        run_req(1'b0, 1'b1, 1'b1, 12'h010, 32'h0, 0, d, e, lat, touched);
        check("lb_pos_byte", d, 32'hFFFFFFEF);

        run_req(1'b0, 1'b0, 1'b0, 12'h013, 32'h0, 0, d, e, lat, touched);
        check("mis_err", 32'(e), 32'd1);
        check("mis_data", d, 32'h0);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_mem_untouched", 32'(touched), 32'd0);
        run_req(1'b1, 1'b0, 1'b0, 12'h012, 32'h11111111, 0, d, e, lat, touched);
        check("mis_store_err", 32'(e), 32'd1);
        check("mis_store_untouched", 32'(touched), 32'd0);

        // Memory accepts but never answers: REQ + 8 WAIT cycles + DONE
        mem_stall = 1'b1;
        run_req(1'b0, 1'b0, 1'b0, 12'h040, 32'h0, 0, d, e, lat, touched);
        check("to_err", 32'(e), 32'd2);
        check("to_data", d, 32'h0);
        check("to_lat", 32'(lat), 32'd10);
        @(negedge clk);
        check("to_ready_after", 32'(ready_o), 32'd1);
        check("to_err_held", 32'(resp_err_o), 32'd2);
        mem_stall = 1'b0;

        // req_v held high for three loads
        y0 = yumi_cnt; nresp = 0; acc = 0;
        req_v = 1'b1; req_wen = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 12'h010;
        for (int i = 0; i < 14; i++) begin
            check("b2b_ready", 32'(ready_o), ((i % 4 == 0) || (i >= 12)) ? 32'd1 : 32'd0);
            if (resp_v_o) begin
                nresp++;
                check("b2b_data", resp_data_o, 32'hDEADBEEF);
                $display("txn b2b resp %0d data=%h err=%0d", nresp, resp_data_o, resp_err_o);
            end
            if (ready_o && req_v) acc++;
            @(negedge clk);
            if (acc == 3) req_v = 1'b0;
        end
        check("b2b_resp_count", 32'(nresp), 32'd3);
        check("b2b_yumi_count", 32'(yumi_cnt - y0), 32'd3);

        // Reset while waiting on a silent memory
        mem_stall = 1'b1;
        req_v = 1'b1; req_addr = 12'h010;
        @(negedge clk);
        req_v = 1'b0;
        @(negedge clk);
        check("rw_in_wait_ready", 32'(ready_o), 32'd0);
        check("rw_in_wait_resp", 32'(resp_v_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rw_ready", 32'(ready_o), 32'd1);
        check("rw_resp_v", 32'(resp_v_o), 32'd0);
        check("rw_mem_valid", 32'(mem_in.valid), 32'd0);
        check("rw_mem_yumi", 32'(mem_in.yumi), 32'd0);
        check("rw_resp_data", resp_data_o, 32'h0);
        check("rw_mem_addr", 32'(mem_addr_o), 32'd0);
        $display("txn reset during WAIT");
        reset = 1'b1; mem_stall = 1'b0;
        @(negedge clk);
        run_req(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, d, e, lat, touched);
        check("post_rst_lw", d, 32'hDEADBEEF);
        check("post_rst_err", 32'(e), 32'd0);

        check("yumi_without_valid", 32'(yumi_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
